// File: rtl/apb_ucpd_pkg.sv
// apb_ucpd_pkg: shared 4b5b/K-code/CRC constants and TX encoder state.
// The state is one packed struct so that a reset and a disable clear it identically.
package apb_ucpd_pkg;

  localparam logic [4:0] K_SYNC1 = 5'b11000;
  localparam logic [4:0] K_SYNC2 = 5'b10001;
  localparam logic [4:0] K_SYNC3 = 5'b00110;
  localparam logic [4:0] K_RST1  = 5'b00111;
  localparam logic [4:0] K_RST2  = 5'b11001;
  localparam logic [4:0] K_EOP   = 5'b01101;

  localparam logic [31:0] CRC_POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_POLY_REF = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [39:0] shift;
    logic [5:0]  cnt;
    logic [31:0] crc;
    logic [31:0] crc_val;
    logic        tog;
    logic        nrz;
    logic        cc;
    logic        pre_q;
    logic        sop_q;
    logic        crc_q;
    logic        eop_q;
    logic [3:0]  hold;
    logic [7:0]  pre_cnt;
  } enc_st_t;

  localparam enc_st_t ST_RST = '{
    shift:   '0,
    cnt:     '0,
    crc:     CRC_INIT,
    crc_val: '0,
    tog:     1'b0,
    nrz:     1'b0,
    cc:      1'b0,
    pre_q:   1'b0,
    sop_q:   1'b0,
    crc_q:   1'b0,
    eop_q:   1'b0,
    hold:    '0,
    pre_cnt: '0
  };

  function automatic logic [4:0] enc4b5b(input logic [3:0] n);
    logic [4:0] s;
    s = 5'b11110;
    case (n)
      4'h0: s = 5'b11110;
      4'h1: s = 5'b01001;
      4'h2: s = 5'b10100;
      4'h3: s = 5'b10101;
      4'h4: s = 5'b01010;
      4'h5: s = 5'b01011;
      4'h6: s = 5'b01110;
      4'h7: s = 5'b01111;
      4'h8: s = 5'b10010;
      4'h9: s = 5'b10011;
      4'hA: s = 5'b10110;
      4'hB: s = 5'b10111;
      4'hC: s = 5'b11010;
      4'hD: s = 5'b11011;
      4'hE: s = 5'b11100;
      4'hF: s = 5'b11101;
      default: s = 5'b11110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/apb_ucpd_tx_enc_if.sv
// apb_ucpd_tx_enc_if: PD TX FSM to symbol encoder bundle.
// master = FSM side, slave = encoder side.
interface apb_ucpd_tx_enc_if;
  logic        ucpden;
  logic        bit_clk_red;
  logic        hbit_clk_red;
  logic        pre_en;
  logic        sop_en;
  logic        data_en;
  logic        crc_en;
  logic        eop_en;
  logic        wait_en;
  logic        txfifo_ld_en;
  logic [7:0]  txdata;
  logic [19:0] tx_ordset;
  logic        cc_tx;
  logic        tx_nrz;
  logic [31:0] crc_val;
  logic        sym_busy;

  modport master (
    output ucpden, bit_clk_red, hbit_clk_red,
    output pre_en, sop_en, data_en,
    output crc_en, eop_en, wait_en,
    output txfifo_ld_en, txdata, tx_ordset,
    input  cc_tx, tx_nrz, crc_val, sym_busy
  );

  modport slave (
    input  ucpden, bit_clk_red, hbit_clk_red,
    input  pre_en, sop_en, data_en,
    input  crc_en, eop_en, wait_en,
    input  txfifo_ld_en, txdata, tx_ordset,
    output cc_tx, tx_nrz, crc_val, sym_busy
  );
endinterface

// File: rtl/apb_ucpd_crc32.sv
// apb_ucpd_crc32: one-byte step of the reflected CRC32.
// Data enters LSB first, matching the bit order on the line.
module apb_ucpd_crc32
  import apb_ucpd_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_acc;

  always_comb begin
    w_acc = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      if (w_acc[0])
        w_acc = (w_acc >> 1) ^ CRC_POLY_REF;
      else
        w_acc = w_acc >> 1;
    end
  end

  assign o_crc = w_acc;

endmodule

// File: rtl/apb_ucpd_tx_enc.sv
// apb_ucpd_tx_enc: 4b5b symbol shifter, CRC32 and BMC driver.
// Loads beat shifts; a load on a strobe still emits the old bit 0.
module apb_ucpd_tx_enc
  import apb_ucpd_pkg::*;
#(
  parameter int PRE_BITS   = 64,
  parameter int HOLD_HBITS = 1
) (
  input logic               ic_clk,
  input logic               ic_rst_n,
  apb_ucpd_tx_enc_if.slave  bus
);

  localparam logic [3:0] HOLD_N = 4'(HOLD_HBITS);

  enc_st_t     r_st;
  enc_st_t     w_nx;
  logic        w_run;
  logic        w_emit;
  logic        w_idle;
  logic        w_pre_rise;
  logic        w_sop_rise;
  logic        w_crc_rise;
  logic        w_eop_rise;
  logic [9:0]  w_ld_sym;
  logic [31:0] w_crc_r;
  logic [39:0] w_crc_sym;
  logic [31:0] w_crc_nxt;

  assign w_run = bus.pre_en | bus.sop_en | bus.data_en
               | bus.crc_en | bus.eop_en;
  assign w_emit = bus.bit_clk_red & w_run;
  assign w_idle = ~(w_run | bus.wait_en);

  assign w_pre_rise = bus.pre_en & ~r_st.pre_q;
  assign w_sop_rise = bus.sop_en & ~r_st.sop_q;
  assign w_crc_rise = bus.crc_en & ~r_st.crc_q;
  assign w_eop_rise = bus.eop_en & ~r_st.eop_q;

  assign w_ld_sym = {enc4b5b(bus.txdata[7:4]),
                     enc4b5b(bus.txdata[3:0])};

  // Residue nibble 0 lands in the low symbol so it goes out first
  always_comb begin
    w_crc_r   = ~r_st.crc;
    w_crc_sym = '0;
    for (int i = 0; i < 8; i++)
      w_crc_sym[5*i +: 5] = enc4b5b(w_crc_r[4*i +: 4]);
  end

  apb_ucpd_crc32 u_crc (
    .i_crc  (r_st.crc),
    .i_data (bus.txdata),
    .o_crc  (w_crc_nxt)
  );

  always_comb begin
    w_nx       = r_st;
    w_nx.pre_q = bus.pre_en;
    w_nx.sop_q = bus.sop_en;
    w_nx.crc_q = bus.crc_en;
    w_nx.eop_q = bus.eop_en;

    if (w_emit) begin
      w_nx.cc = ~r_st.cc;
      if (bus.pre_en) begin
        w_nx.nrz = r_st.tog;
        w_nx.tog = ~r_st.tog;
        if (r_st.pre_cnt != 8'hFF)
          w_nx.pre_cnt = r_st.pre_cnt + 8'd1;
      end else begin
        w_nx.nrz   = r_st.shift[0];
        w_nx.shift = {1'b0, r_st.shift[39:1]};
        if (r_st.cnt != 6'd0)
          w_nx.cnt = r_st.cnt - 6'd1;
      end
    end else if (bus.hbit_clk_red && w_run && r_st.nrz) begin
      w_nx.cc = ~r_st.cc;
    end
    if (!bus.pre_en)
      w_nx.pre_cnt = '0;

    if (bus.txfifo_ld_en) begin
      w_nx.shift = {30'b0, w_ld_sym};
      w_nx.cnt   = 6'd10;
      w_nx.crc   = w_crc_nxt;
    end else if (w_sop_rise) begin
      w_nx.shift = {20'b0, bus.tx_ordset};
      w_nx.cnt   = 6'd20;
    end else if (w_crc_rise) begin
      w_nx.shift   = w_crc_sym;
      w_nx.cnt     = 6'd40;
      w_nx.crc_val = w_crc_r;
    end else if (w_eop_rise) begin
      w_nx.shift = {35'b0, K_EOP};
      w_nx.cnt   = 6'd5;
    end else if (w_pre_rise) begin
      w_nx.crc = CRC_INIT;
      w_nx.tog = 1'b0;
    end

    // Keep the final EOP level for HOLD_HBITS half bits, then park low
    if (bus.wait_en) begin
      if (r_st.hold >= HOLD_N) begin
        w_nx.cc = 1'b0;
      end else if (bus.hbit_clk_red) begin
        w_nx.hold = r_st.hold + 4'd1;
        if (r_st.hold + 4'd1 >= HOLD_N)
          w_nx.cc = 1'b0;
      end
    end else begin
      w_nx.hold = '0;
    end

    if (w_idle) begin
      w_nx.cc  = 1'b0;
      w_nx.tog = 1'b0;
    end
  end

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n)
      r_st <= ST_RST;
    else if (!bus.ucpden)
      r_st <= ST_RST;
    else
      r_st <= w_nx;
  end

  assign bus.cc_tx    = r_st.cc;
  assign bus.tx_nrz   = r_st.nrz;
  assign bus.crc_val  = r_st.crc_val;
  assign bus.sym_busy = |r_st.cnt;

  a_ld_phase: assert property (
    @(posedge ic_clk) disable iff (!ic_rst_n)
    (bus.ucpden && bus.txfifo_ld_en) |->
      (bus.sop_en || bus.data_en));

  a_ld_rise: assert property (
    @(posedge ic_clk) disable iff (!ic_rst_n)
    (bus.ucpden && bus.txfifo_ld_en) |->
      !(w_pre_rise || w_sop_rise || w_crc_rise || w_eop_rise));

  a_pre_len: assert property (
    @(posedge ic_clk) disable iff (!ic_rst_n)
    int'(r_st.pre_cnt) <= PRE_BITS);

endmodule

// File: tb/tb_apb_ucpd_tx_enc.sv
// tb_apb_ucpd_tx_enc: directed frames with a queued scoreboard on tx_nrz/sym_busy.
// The monitor also checks the BMC transition rule at every bit and half-bit strobe.
module tb_apb_ucpd_tx_enc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_ucpd_tx_enc_if bus ();

  apb_ucpd_tx_enc #(
    .PRE_BITS   (64),
    .HOLD_HBITS (1)
  ) dut (
    .ic_clk   (clk),
    .ic_rst_n (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic nrz;
    logic busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // 4b5b codes written in transmit order (bit 0 first)
  string SENT [16] = '{
    "01111", "10010", "00101", "10101",
    "01010", "11010", "01110", "11110",
    "01001", "11001", "01101", "11101",
    "01011", "11011", "00111", "10111"
  };

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic tb_run;
  assign tb_run = bus.pre_en | bus.sop_en | bus.data_en
                | bus.crc_en | bus.eop_en;

  logic m_emit = 1'b0;
  logic m_hb = 1'b0;
  logic m_cc_prev = 1'b0;

  always @(posedge clk) begin
    m_emit <= bus.ucpden & bus.bit_clk_red & tb_run;
    m_hb   <= bus.ucpden & bus.hbit_clk_red & tb_run;
  end

  always @(negedge clk) begin
    exp_t e;
    logic want;
    if (m_emit) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=strobe required=no_strobe");
      end else begin
        e = q.pop_front();
        chk("tx_nrz", {31'b0, bus.tx_nrz}, {31'b0, e.nrz});
        chk("sym_busy", {31'b0, bus.sym_busy}, {31'b0, e.busy});
      end
      want = ~m_cc_prev;
      chk("bmc_bit", {31'b0, bus.cc_tx}, {31'b0, want});
    end
    if (m_hb) begin
      want = m_cc_prev ^ bus.tx_nrz;
      chk("bmc_half", {31'b0, bus.cc_tx}, {31'b0, want});
    end
    m_cc_prev <= bus.cc_tx;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic bitp();
    bus.bit_clk_red = 1'b1;
    cyc();
    bus.bit_clk_red = 1'b0;
    cyc();
    bus.hbit_clk_red = 1'b1;
    cyc();
    bus.hbit_clk_red = 1'b0;
    cyc();
  endtask

  task automatic hbit();
    bus.hbit_clk_red = 1'b1;
    cyc();
    bus.hbit_clk_red = 1'b0;
    cyc();
  endtask

  task automatic push(logic nrz, logic busy);
    exp_t e;
    e.nrz = nrz;
    e.busy = busy;
    q.push_back(e);
  endtask

  task automatic send(string s, int cnt0);
    for (int j = 0; j < s.len(); j++) begin
      push(s.getc(j) == "1", (cnt0 - 1 - j) > 0);
      bitp();
    end
  endtask

  task automatic load(logic [7:0] b);
    bus.txfifo_ld_en = 1'b1;
    bus.txdata = b;
    cyc();
    bus.txfifo_ld_en = 1'b0;
    bus.txdata = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ucpden = 1'b0;
    bus.bit_clk_red = 1'b0;
    bus.hbit_clk_red = 1'b0;
    bus.pre_en = 1'b0;
    bus.sop_en = 1'b0;
    bus.data_en = 1'b0;
    bus.crc_en = 1'b0;
    bus.eop_en = 1'b0;
    bus.wait_en = 1'b0;
    bus.txfifo_ld_en = 1'b0;
    bus.txdata = 8'h00;
    bus.tx_ordset = {5'b10001, 5'b11000, 5'b11000, 5'b11000};
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_cc", {31'b0, bus.cc_tx}, 32'd0);
    chk("rst_nrz", {31'b0, bus.tx_nrz}, 32'd0);
    chk("rst_crc_val", bus.crc_val, 32'd0);
    chk("rst_busy", {31'b0, bus.sym_busy}, 32'd0);

    bus.ucpden = 1'b1;
    cyc();
    chk("cc_idle", {31'b0, bus.cc_tx}, 32'd0);

    // Frame 1: preamble, SOP, "123456789", CRC, EOP
    bus.pre_en = 1'b1;
    cyc();
    for (int k = 0; k < 64; k++) begin
      push(k[0], 1'b0);
      bitp();
    end
    bus.pre_en = 1'b0;
    bus.sop_en = 1'b1;
    cyc();
    send("00011000110001110001", 20);
    bus.sop_en = 1'b0;
    bus.data_en = 1'b1;
    cyc();
    for (int b = 1; b <= 9; b++) begin
      load(8'h30 + 8'(b));
      send({SENT[b], SENT[3]}, 10);
    end
    bus.data_en = 1'b0;
    bus.crc_en = 1'b1;
    cyc();
    chk("crc_val", bus.crc_val, 32'hCBF4_3926);
    send({SENT[6], SENT[2], SENT[9], SENT[3],
          SENT[4], SENT[15], SENT[11], SENT[12]}, 40);
    bus.crc_en = 1'b0;
    bus.eop_en = 1'b1;
    cyc();
    send("10110", 5);
    bus.eop_en = 1'b0;
    bus.wait_en = 1'b1;
    cyc();
    hbit();
    chk("cc_wait_low", {31'b0, bus.cc_tx}, 32'd0);
    bus.wait_en = 1'b0;
    cyc();
    chk("cc_idle2", {31'b0, bus.cc_tx}, 32'd0);

    // Frame 2: 0xA5, then hard-reset truncation 3 bits into 0x00
    bus.data_en = 1'b1;
    cyc();
    load(8'hA5);
    send({SENT[5], SENT[10]}, 10);
    load(8'h00);
    send("011", 10);
    bus.data_en = 1'b0;
    bus.eop_en = 1'b1;
    cyc();
    chk("busy_eop_load", {31'b0, bus.sym_busy}, 32'd1);
    send("10110", 5);
    bus.eop_en = 1'b0;
    bus.wait_en = 1'b1;
    cyc();
    cyc();
    chk("cc_hold", {31'b0, bus.cc_tx}, 32'd1);
    hbit();
    chk("cc_hold_end", {31'b0, bus.cc_tx}, 32'd0);
    bus.wait_en = 1'b0;
    cyc();

    // Frame 3: ucpden dropped mid-data
    bus.data_en = 1'b1;
    cyc();
    load(8'h12);
    send("0010", 10);
    chk("cc_pre_abort", {31'b0, bus.cc_tx}, 32'd1);
    bus.ucpden = 1'b0;
    cyc();
    chk("abort_cc", {31'b0, bus.cc_tx}, 32'd0);
    chk("abort_busy", {31'b0, bus.sym_busy}, 32'd0);
    chk("abort_nrz", {31'b0, bus.tx_nrz}, 32'd0);
    chk("abort_crc_val", bus.crc_val, 32'd0);
    bus.ucpden = 1'b1;
    cyc();
    for (int b = 1; b <= 9; b++)
      load(8'h30 + 8'(b));
    bus.data_en = 1'b0;
    bus.crc_en = 1'b1;
    cyc();
    chk("crc_reinit", bus.crc_val, 32'hCBF4_3926);
    chk("busy_crc_load", {31'b0, bus.sym_busy}, 32'd1);
    bus.crc_en = 1'b0;
    cyc();
    cyc();
    chk("sb_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_ucpd_tx_enc.md
Name: apb_ucpd_tx_enc

Overview:
- TX symbol encoder and BMC line driver, directly downstream of the PD main TX FSM in the ic_clk domain.
- Consumes the FSM phase enables (pre/sop/data/crc/eop/wait) and per-bit strobes, and receives the TX data byte on each FSM load pulse.
- Produces the 4b5b-encoded, CRC32-protected, BMC-coded CC line level. All bits are transmitted bit 0 first.

Parameters:
- PRE_BITS, 64, preamble length in bits; informational only, because the FSM terminates the phase.
- HOLD_HBITS, 1, number of half-bit strobes the line stays at its final level after EOP before it is forced low during wait.

Ports:
- ic_clk  in  1  usbpd kernel clock (HSI16)
- ic_rst_n  in  1  asynchronous active-low reset
- ucpden  in  1  block enable; when 0, synchronously clears all state
- bit_clk_red  in  1  one-cycle strobe at each bit boundary
- hbit_clk_red  in  1  one-cycle strobe at each mid-bit point; never coincident with bit_clk_red
- pre_en, sop_en, data_en, crc_en, eop_en, wait_en  in  1 each  FSM phase, one-hot or all 0
- txfifo_ld_en  in  1  load pulse for the next data byte
- txdata  in  8  data byte; valid only while txfifo_ld_en=1
- tx_ordset  in  20  SOP ordered set, four K-codes; K0 is in [4:0] and is sent first
- cc_tx  out  1  BMC line level
- tx_nrz  out  1  current unencoded line bit (debug/BIST)
- crc_val  out  32  final transmitted CRC, complemented
- sym_busy  out  1  shifter holds untransmitted bits

Behaviour:
- Reset or ucpden=0:
  - cc_tx=0, tx_nrz=0, crc_val=0, sym_busy=0.
  - shifter=0, bit count=0, CRC=32'hFFFF_FFFF, preamble toggle=0.
- Emission on each bit_clk_red while (pre|sop|data|crc|eop)_en:
  - Preamble phase: tx_nrz <= pre toggle, then the toggle inverts. The preamble therefore reads 0,1,0,1,...
  - Other phases: tx_nrz <= shifter[0] and the shifter shifts right, filling with 0.
- Loads:
  - Priority is load > shift.
  - A load on a strobe cycle still emits the old shifter[0].
  - Rising edge of sop_en (first cycle): shifter <= tx_ordset.
  - txfifo_ld_en: shifter <= {enc(txdata[7:4]), enc(txdata[3:0])}, so the low nibble goes first. In the same cycle, CRC <= crc_next(CRC, txdata).
  - Rising edge of crc_en: R = ~CRC. shifter (40b) <= enc of nibbles R[3:0], R[7:4], ..., R[31:28], in that order. crc_val <= R.
  - Rising edge of eop_en: shifter <= EOP K-code. Any remaining data/CRC bits are discarded, which covers the hard-reset truncation path.
  - Rising edge of pre_en: CRC <= 32'hFFFF_FFFF, toggle <= 0.
- sym_busy = 1 while the bit count is non-zero.
  - The count is set to the width of each load (10, 20, 40 or 5).
  - It decrements on each shift.
- BMC coding:
  - On each active bit_clk_red, cc_tx inverts.
  - On hbit_clk_red, cc_tx inverts again if tx_nrz=1.
  - The first preamble transition starts from cc_tx=0.
- End of frame:
  - Once wait_en is asserted, cc_tx holds for HOLD_HBITS half-bit strobes and is then driven to 0.
  - When all enables are 0, cc_tx=0 and the toggle resets.
- txfifo_ld_en outside sop/data phases: the load is still performed and the CRC is updated. FSM guarantees this does not occur; the assertion fires.
- Simultaneous phase rise and txfifo_ld_en: txfifo_ld_en wins. Assertion only.
- ucpden falling mid-frame: all state is cleared on the next cycle and cc_tx=0.
- Latency: each output changes one ic_clk after its strobe.

Decomposition:
- Package apb_ucpd_pkg holds:
  - The 4b5b table, given MSB..LSB: 0:11110, 1:01001, 2:10100, 3:10101, 4:01010, 5:01011, 6:01110, 7:01111, 8:10010, 9:10011, A:10110, B:10111, C:11010, D:11011, E:11100, F:11101.
  - K-codes: SYNC1 11000, SYNC2 10001, SYNC3 00110, RST1 00111, RST2 11001, EOP 01101.
  - CRC constants: poly 32'h04C11DB7 reflected (32'hEDB88320), init 32'hFFFF_FFFF.
- Sub-module apb_ucpd_crc32: combinational byte-wide reflected CRC32 next-state.

Test Plan:
- Preamble: pre_en held for 64 strobes -> tx_nrz alternates starting at 0; cc_tx has mid-bit transitions only on 1-bits.
- SOP: tx_ordset={SYNC2,SYNC1,SYNC1,SYNC1} -> 20 bits on tx_nrz, bit 0 first: 0,0,0,1,1 x3 then 1,0,0,0,1.
- CRC vector: data bytes "123456789" (0x31..0x39) -> crc_val=32'hCBF43926; CRC phase emits 40 bits that are enc of nibbles 6,2,9,3,4,F,B,C in that order.
- Single byte 0xA5: load -> 10 bits 01011 (nibble 5) then 10110 (nibble A), each bit 0 first.
- Hard-reset abort: eop_en rises 3 bits into a data byte -> the next 5 bits are EOP, sym_busy clears after 5 strobes, then the wait hold and cc_tx=0.
- ucpden deasserted mid-data -> next cycle cc_tx=0, sym_busy=0, CRC reinitialised.
